// File: rtl/div_unit.sv
// Iterative 32-cycle restoring divider for the execute stage (DIV/DIVU).
// Result is {remainder, quotient}; the request handshake holds the result until start_i drops.
module div_unit #(
    parameter int DATA_W = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  signed_div_i,
    input  logic [DATA_W-1:0]     opdata1_i,
    input  logic [DATA_W-1:0]     opdata2_i,
    input  logic                  start_i,
    input  logic                  annul_i,
    output logic [2*DATA_W-1:0]   result_o,
    output logic                  ready_o,
    output logic                  busy_o
);

    localparam int CNT_W = $clog2(DATA_W) + 1;
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(DATA_W);

    typedef enum logic [1:0] {FREE, BYZERO, ON, END} state_t;

    state_t              state_q, state_d;
    logic [CNT_W-1:0]    cnt_q;
    logic [DATA_W-1:0]   rem_q;
    logic [DATA_W-1:0]   quo_q;
    logic [DATA_W-1:0]   dvs_q;
    logic                neg_quo_q;
    logic                neg_rem_q;

    logic [DATA_W:0]     shifted;
    logic [DATA_W-1:0]   diff;
    logic                fits;
    logic [DATA_W-1:0]   rem_nxt;
    logic                accept;
    logic                dvd_neg;
    logic                dvs_neg;

    function automatic logic [DATA_W-1:0] cond_neg(input logic [DATA_W-1:0] v,
                                                   input logic neg);
        logic signed [DATA_W-1:0] sv;
        sv = v;
        return neg ? DATA_W'(-sv) : v;
    endfunction

    assign accept  = start_i && !annul_i;
    assign dvd_neg = signed_div_i && opdata1_i[DATA_W-1];
    assign dvs_neg = signed_div_i && opdata2_i[DATA_W-1];
    assign busy_o  = (state_q != FREE);

    // One restoring step: the dividend sits in quo_q and leaves MSB first
    // while quotient bits enter at the LSB.
    always_comb begin
        shifted = {rem_q, quo_q[DATA_W-1]};
        fits    = (shifted >= {1'b0, dvs_q});
        diff    = shifted[DATA_W-1:0] - dvs_q;
        rem_nxt = fits ? diff : shifted[DATA_W-1:0];
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state_q <= FREE;
        else      state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            FREE:    if (accept) state_d = (opdata2_i == '0) ? BYZERO : ON;
            BYZERO:  state_d = annul_i ? FREE : END;
            ON: begin
                if (annul_i)                state_d = FREE;
                else if (cnt_q == LAST_CNT) state_d = END;
            end
            END:     if (!start_i) state_d = FREE;
            default: state_d = FREE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_q     <= '0;
            rem_q     <= '0;
            quo_q     <= '0;
            dvs_q     <= '0;
            neg_quo_q <= 1'b0;
            neg_rem_q <= 1'b0;
            result_o  <= '0;
            ready_o   <= 1'b0;
        end else begin
            case (state_q)
                FREE: begin
                    if (accept) begin
                        cnt_q     <= '0;
                        rem_q     <= '0;
                        quo_q     <= cond_neg(opdata1_i, dvd_neg);
                        dvs_q     <= cond_neg(opdata2_i, dvs_neg);
                        neg_quo_q <= dvd_neg ^ dvs_neg;
                        neg_rem_q <= dvd_neg;
                    end
                end
                BYZERO: begin
                    if (!annul_i) begin
                        result_o <= '0;
                        ready_o  <= 1'b1;
                    end
                end
                ON: begin
                    if (!annul_i) begin
                        if (cnt_q == LAST_CNT) begin
                            result_o <= {cond_neg(rem_q, neg_rem_q),
                                         cond_neg(quo_q, neg_quo_q)};
                            ready_o  <= 1'b1;
                        end else begin
                            rem_q <= rem_nxt;
                            quo_q <= {quo_q[DATA_W-2:0], fits};
                            cnt_q <= cnt_q + CNT_W'(1);
                        end
                    end
                end
                END: begin
                    if (!start_i) begin
                        result_o <= '0;
                        ready_o  <= 1'b0;
                    end
                end
                default: begin
                    result_o <= '0;
                    ready_o  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_div_unit.sv
// Directed bench for div_unit: signed/unsigned quotients, divide-by-zero,
// overflow wrap, annul and asynchronous reset behaviour.
module tb_div_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic        signed_div_i;
    logic [31:0] opdata1_i;
    logic [31:0] opdata2_i;
    logic        start_i;
    logic        annul_i;
    logic [63:0] result_o;
    logic        ready_o;
    logic        busy_o;

    int n_checks = 0;
    int n_fail   = 0;
    int lat;

    div_unit dut (
        .clk          (clk),
        .rst          (rst),
        .signed_div_i (signed_div_i),
        .opdata1_i    (opdata1_i),
        .opdata2_i    (opdata2_i),
        .start_i      (start_i),
        .annul_i      (annul_i),
        .result_o     (result_o),
        .ready_o      (ready_o),
        .busy_o       (busy_o)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Present a request, pass the acceptance edge, scramble the inputs, then
    // count edges until ready_o (bounded).
    task automatic run_div(input string tag, input logic sgn, input logic [31:0] a,
                           input logic [31:0] b, output int cycles);
        signed_div_i = sgn;
        opdata1_i    = a;
        opdata2_i    = b;
        start_i      = 1'b1;
        annul_i      = 1'b0;
        @(posedge clk); #1;
        chk({tag, "_busy_e0"}, 64'(busy_o), 64'd1);
        opdata1_i    = $urandom;
        opdata2_i    = $urandom;
        signed_div_i = ~sgn;
        cycles = 0;
        while (ready_o !== 1'b1 && cycles < 40) begin
            @(posedge clk); #1;
            cycles++;
        end
    endtask

    task automatic do_div(input string tag, input logic sgn, input logic [31:0] a,
                          input logic [31:0] b, input logic [63:0] exp_res, input int exp_lat);
        int c;
        run_div(tag, sgn, a, b, c);
        chk({tag, "_latency"}, 64'(c), 64'(exp_lat));
        chk({tag, "_result"}, result_o, exp_res);
        // Held in END while start_i stays high; annul_i is ignored there.
        annul_i = 1'b1;
        @(posedge clk); #1;
        annul_i = 1'b0;
        chk({tag, "_hold_result"}, result_o, exp_res);
        chk({tag, "_hold_ready"}, 64'(ready_o), 64'd1);
        start_i = 1'b0;
        @(posedge clk); #1;
        chk({tag, "_rel_ready"}, 64'(ready_o), 64'd0);
        chk({tag, "_rel_result"}, result_o, 64'd0);
        chk({tag, "_rel_busy"}, 64'(busy_o), 64'd0);
    endtask

    initial begin
        rst = 1'b0; start_i = 1'b0; annul_i = 1'b0; signed_div_i = 1'b0;
        opdata1_i = '0; opdata2_i = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_result", result_o, 64'd0);
        chk("reset_ready", 64'(ready_o), 64'd0);
        chk("reset_busy", 64'(busy_o), 64'd0);
        rst = 1'b1;

        do_div("s_7_by_m2", 1'b1, 32'd7, 32'hFFFF_FFFE, {32'h0000_0001, 32'hFFFF_FFFD}, 33);
        do_div("u_max_by_16", 1'b0, 32'hFFFF_FFFF, 32'h10, {32'h0000_000F, 32'h0FFF_FFFF}, 33);
        do_div("u_by_zero", 1'b0, 32'd123, 32'd0, 64'd0, 1);
        do_div("s_by_zero", 1'b1, 32'h8000_0000, 32'd0, 64'd0, 1);
        do_div("s_min_by_m1", 1'b1, 32'h8000_0000, 32'hFFFF_FFFF, {32'h0, 32'h8000_0000}, 33);
        do_div("s_m7_by_2", 1'b1, 32'hFFFF_FFF9, 32'd2, {32'hFFFF_FFFF, 32'hFFFF_FFFD}, 33);
        do_div("u_min_by_max", 1'b0, 32'h8000_0000, 32'hFFFF_FFFF, {32'h8000_0000, 32'h0}, 33);
        do_div("s_m100_by_m7", 1'b1, 32'hFFFF_FF9C, 32'hFFFF_FFF9, {32'hFFFF_FFFE, 32'h0000_000E}, 33);

        // Annul during iteration 10, then a fresh request on the next edge.
        signed_div_i = 1'b0; opdata1_i = 32'd1000; opdata2_i = 32'd3;
        start_i = 1'b1; annul_i = 1'b0;
        @(posedge clk); #1;
        repeat (9) @(posedge clk);
        #1;
        chk("annul_pre_ready", 64'(ready_o), 64'd0);
        chk("annul_pre_busy", 64'(busy_o), 64'd1);
        annul_i = 1'b1;
        @(posedge clk); #1;
        chk("annul_busy", 64'(busy_o), 64'd0);
        chk("annul_ready", 64'(ready_o), 64'd0);
        chk("annul_result", result_o, 64'd0);
        do_div("after_annul", 1'b0, 32'd100, 32'd7, {32'h0000_0002, 32'h0000_000E}, 33);

        // Annul in BYZERO aborts without ready.
        signed_div_i = 1'b0; opdata1_i = 32'd5; opdata2_i = 32'd0; start_i = 1'b1;
        @(posedge clk); #1;
        annul_i = 1'b1;
        @(posedge clk); #1;
        annul_i = 1'b0;
        chk("byzero_annul_busy", 64'(busy_o), 64'd0);
        chk("byzero_annul_ready", 64'(ready_o), 64'd0);

        // start_i with annul_i in FREE is not accepted.
        opdata2_i = 32'd1; annul_i = 1'b1;
        @(posedge clk); #1;
        chk("free_annul_busy", 64'(busy_o), 64'd0);
        annul_i = 1'b0; start_i = 1'b0;
        @(posedge clk); #1;

        // Asynchronous reset between edges during iteration 20.
        signed_div_i = 1'b0; opdata1_i = 32'd77; opdata2_i = 32'd5; start_i = 1'b1;
        @(posedge clk); #1;
        repeat (20) @(posedge clk);
        #3;
        rst = 1'b0;
        #1;
        chk("async_rst_busy", 64'(busy_o), 64'd0);
        chk("async_rst_ready", 64'(ready_o), 64'd0);
        chk("async_rst_result", result_o, 64'd0);
        #2;
        rst = 1'b1;
        do_div("after_reset", 1'b0, 32'd9, 32'd3, {32'h0, 32'h3}, 33);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/div_unit.md
DIV_UNIT -- requirements
Module: div_unit

Interface
REQ-001 SHALL have clock `clk`, input, 1 bit: all state changes on its rising edge; one clock only.
REQ-002 SHALL have reset `rst`, input, 1 bit: asynchronous, active-low (0 = reset), takes effect immediately without waiting for `clk`.
REQ-003 SHALL have `signed_div_i`, input, 1 bit: 1 = DIV (two's complement), 0 = DIVU.
REQ-004 SHALL have `opdata1_i`, input, 32 bits: dividend.
REQ-005 SHALL have `opdata2_i`, input, 32 bits: divisor.
REQ-006 SHALL have `start_i`, input, 1 bit: request from the execute stage, held high until `ready_o` is seen.
REQ-007 SHALL have `annul_i`, input, 1 bit: abort the current division (flush or branch cancel).
REQ-008 SHALL have `result_o`, output, 64 bits: {remainder[63:32], quotient[31:0]}; the execute stage drives {hi, lo} from these.
REQ-009 SHALL have `ready_o`, output, 1 bit: `result_o` is valid.
REQ-010 SHALL have `busy_o`, output, 1 bit: 1 in every state except FREE; used by the execute stage to stall.

Function
REQ-011 SHALL implement exactly four states:
- FREE
- BYZERO
- ON
- END
REQ-012 In FREE with `start_i`=1 and `annul_i`=0, the unit SHALL sample `opdata1_i`, `opdata2_i` and `signed_div_i` on that edge (the acceptance edge, E0).
REQ-013 If the sampled divisor is 0, the unit SHALL go to BYZERO; otherwise it SHALL go to ON with the iteration counter cnt=0.
REQ-014 Input changes after E0 SHALL be ignored until the unit returns to FREE.
REQ-015 On acceptance in signed mode, negative operands SHALL be replaced by their two's-complement magnitude; in unsigned mode operands SHALL be used unchanged.
REQ-016 ON SHALL perform one restoring-division step per cycle:
- shift the partial remainder left by one and bring in the next dividend bit, MSB first;
- subtract the divisor magnitude as a 33-bit difference;
- if non-negative, keep the difference and shift in quotient bit 1;
- else keep the shifted remainder and shift in quotient bit 0;
- increment cnt.
REQ-017 On edges E1..E32 the unit SHALL perform iterations 1..32.
REQ-018 On edge E33 (cnt==32), the unit SHALL apply the sign fix-up, go to END and set `ready_o`=1.
REQ-019 Sign fix-up (signed mode only):
- quotient negated iff the dividend and divisor signs differ;
- remainder negated iff the dividend is negative;
- all arithmetic modulo 2^32.
REQ-020 For 0x80000000 / 0xFFFFFFFF in signed mode, the result SHALL be quotient 0x80000000, remainder 0 (wrap, no trap).
REQ-021 BYZERO SHALL go to END on the next edge (E1) with `result_o`=0 and `ready_o`=1.
REQ-022 In END, `result_o` and `ready_o` SHALL hold stable while `start_i`=1.
REQ-023 In END with `start_i`=0, the unit SHALL go to FREE with `ready_o`=0 and `result_o`=0 on that edge.
REQ-024 A new request SHALL be accepted no earlier than the edge after the return to FREE.
REQ-025 `annul_i`=1 sampled in BYZERO or ON SHALL force FREE on that edge, with `ready_o` never asserted for that request.
REQ-026 `annul_i` in FREE SHALL block acceptance that cycle.
REQ-027 `annul_i` in END SHALL be ignored.
REQ-028 Deassertion of `start_i` during BYZERO or ON SHALL be ignored; only `annul_i` aborts.
REQ-029 Simultaneous `start_i`=1 and `annul_i`=1 in FREE SHALL leave the unit in FREE.
REQ-030 `ready_o` SHALL be high only in END.
REQ-031 `result_o` SHALL be 0 in every state except END.
REQ-032 `busy_o` SHALL be combinational from state.
REQ-033 Latency:
- 33 cycles from acceptance to `ready_o` for a nonzero divisor;
- 1 cycle for a zero divisor.

Reset
REQ-034 While `rst`=0, the unit SHALL immediately set state=FREE, cnt=0, the internal remainder/quotient registers to 0, `result_o`=0, `ready_o`=0 and `busy_o`=0, regardless of `clk`.
REQ-035 Reset asserted mid-division SHALL discard the operation.
REQ-036 After `rst` rises, the first `clk` edge with `start_i`=1 SHALL be accepted.

Verification
REQ-037 Signed 7 / 0xFFFFFFFE (-2) -> `ready_o` rises after E33; `result_o` = {0x00000001, 0xFFFFFFFD}.
REQ-038 Unsigned 0xFFFFFFFF / 0x00000010 -> `result_o` = {0x0000000F, 0x0FFFFFFF}; held stable while `start_i`=1; drops to 0 with `ready_o`=0 one edge after `start_i`=0.
REQ-039 Divisor 0 (either mode) -> BYZERO at E0, END at E1, `result_o`=0, `ready_o`=1; `busy_o`=1 from E0.
REQ-040 Signed 0x80000000 / 0xFFFFFFFF -> {0x00000000, 0x80000000}; signed 0xFFFFFFF9 (-7) / 2 -> {0xFFFFFFFF, 0xFFFFFFFD}.
REQ-041 Annul during iteration 10 -> FREE on that edge, `ready_o` stays 0; a new 100 / 7 request accepted next edge -> {0x00000002, 0x0000000E} after 33 cycles.
REQ-042 `rst`=0 pulse between clock edges at iteration 20 -> outputs 0 and state FREE immediately, before the next edge; no `ready_o` for the aborted request.
